// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result producers (ALU, load) each feed a small FIFO,
// and one registered broadcast per cycle is drawn from them with alternating priority.

module cdb_arb_fifo #(
  parameter int ROB_BIT = 4,
  parameter int QDEPTH  = 2,
  parameter int CW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ROB_BIT-1:0] push_src,
  input  logic [31:0]        push_val,
  input  logic               pop,
  output logic [ROB_BIT-1:0] head_src,
  output logic [31:0]        head_val,
  output logic [CW-1:0]      count
);

  localparam int PW = $clog2(QDEPTH);

  logic [ROB_BIT-1:0] src_mem [QDEPTH];
  logic [31:0]        val_mem [QDEPTH];
  logic [PW-1:0]      wp;
  logic [PW-1:0]      rp;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wp] <= push_src;
      val_mem[wp] <= push_val;
    end
  end

  assign head_src = src_mem[rp];
  assign head_val = val_mem[rp];

endmodule

module cdb_arbiter #(
  parameter int ROB_BIT = 4,
  parameter int QDEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rb,
  input  logic               alu_valid,
  input  logic [ROB_BIT-1:0] alu_src,
  input  logic [31:0]        alu_val,
  output logic               alu_ack,
  input  logic               ld_valid,
  input  logic [ROB_BIT-1:0] ld_src,
  input  logic [31:0]        ld_val,
  output logic               ld_ack,
  output logic               cdb_valid,
  output logic [ROB_BIT-1:0] cdb_src,
  output logic [31:0]        cdb_val,
  output logic               cdb_from_ld
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic               active;
  logic               alu_push, ld_push;
  logic               alu_ne, ld_ne;
  logic               grant_alu, grant_ld;
  logic               prio;
  logic [CW-1:0]      alu_count, ld_count;
  logic [ROB_BIT-1:0] alu_head_src, ld_head_src;
  logic [31:0]        alu_head_val, ld_head_val;

  // Handshake: a result transfers on a posedge where valid && ack; ack depends only on
  // the active condition and the registered queue count, so a full queue never takes a
  // push even when it is popped in the same cycle. Tag 0 is acked but silently dropped.
  assign active   = rst && rdy && !rb;
  assign alu_ack  = active && (alu_count < FULL);
  assign ld_ack   = active && (ld_count < FULL);
  assign alu_push = alu_valid && alu_ack && (alu_src != '0);
  assign ld_push  = ld_valid && ld_ack && (ld_src != '0);

  assign alu_ne    = (alu_count != '0);
  assign ld_ne     = (ld_count != '0);
  assign grant_alu = active && alu_ne && (!ld_ne || !prio);
  assign grant_ld  = active && ld_ne && (!alu_ne || prio);

  cdb_arb_fifo #(.ROB_BIT(ROB_BIT), .QDEPTH(QDEPTH), .CW(CW)) u_alu_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (rb),
    .push     (alu_push),
    .push_src (alu_src),
    .push_val (alu_val),
    .pop      (grant_alu),
    .head_src (alu_head_src),
    .head_val (alu_head_val),
    .count    (alu_count)
  );

  cdb_arb_fifo #(.ROB_BIT(ROB_BIT), .QDEPTH(QDEPTH), .CW(CW)) u_ld_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (rb),
    .push     (ld_push),
    .push_src (ld_src),
    .push_val (ld_val),
    .pop      (grant_ld),
    .head_src (ld_head_src),
    .head_val (ld_head_val),
    .count    (ld_count)
  );

  // Priority only rotates when both sides actually contended.
  always_ff @(posedge clk) begin
    if (!rst || rb) begin
      prio <= 1'b0;
    end else if (active && alu_ne && ld_ne) begin
      prio <= !prio;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid   <= 1'b0;
      cdb_src     <= '0;
      cdb_val     <= '0;
      cdb_from_ld <= 1'b0;
    end else if (grant_alu) begin
      cdb_valid   <= 1'b1;
      cdb_src     <= alu_head_src;
      cdb_val     <= alu_head_val;
      cdb_from_ld <= 1'b0;
    end else if (grant_ld) begin
      cdb_valid   <= 1'b1;
      cdb_src     <= ld_head_src;
      cdb_val     <= ld_head_val;
      cdb_from_ld <= 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised bench for cdb_arbiter: a queue-level reference model predicts every
// broadcast into exp_q and a negedge monitor checks what the DUT puts on the bus.

module tb_cdb_arbiter;

  localparam int ROB_BIT = 4;
  localparam int QDEPTH  = 2;
  localparam int W       = 1 + ROB_BIT + 32;

  typedef struct packed {
    logic [ROB_BIT-1:0] src;
    logic [31:0]        val;
  } ent_t;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, rdy, rb;
  logic               alu_valid, ld_valid;
  logic [ROB_BIT-1:0] alu_src, ld_src;
  logic [31:0]        alu_val, ld_val;
  logic               alu_ack, ld_ack;
  logic               cdb_valid, cdb_from_ld;
  logic [ROB_BIT-1:0] cdb_src;
  logic [31:0]        cdb_val;

  cdb_arbiter #(.ROB_BIT(ROB_BIT), .QDEPTH(QDEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rb          (rb),
    .alu_valid   (alu_valid),
    .alu_src     (alu_src),
    .alu_val     (alu_val),
    .alu_ack     (alu_ack),
    .ld_valid    (ld_valid),
    .ld_src      (ld_src),
    .ld_val      (ld_val),
    .ld_ack      (ld_ack),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .cdb_val     (cdb_val),
    .cdb_from_ld (cdb_from_ld)
  );

  // reference model state and scoreboard
  ent_t         mq_alu[$];
  ent_t         mq_ld[$];
  logic         m_prio = 1'b0;
  logic [W-1:0] exp_q[$];
  logic         exp_valid = 1'b0;
  logic         started = 1'b0;
  logic         a_acc, l_acc;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // driver: inputs are already set; predict acks and the next edge, then clock it
  task automatic step();
    logic act, a_ack_e, l_ack_e, gnt, side;
    ent_t e;
    #1;
    act     = rst && rdy && !rb;
    a_ack_e = act && (mq_alu.size() < QDEPTH);
    l_ack_e = act && (mq_ld.size() < QDEPTH);
    check("alu_ack", W'(alu_ack), W'(a_ack_e));
    check("ld_ack", W'(ld_ack), W'(l_ack_e));
    a_acc = alu_valid && a_ack_e;
    l_acc = ld_valid && l_ack_e;
    gnt   = 1'b0;
    side  = 1'b0;
    if (!rst || rb) begin
      mq_alu.delete();
      mq_ld.delete();
      m_prio = 1'b0;
    end else if (rdy) begin
      if (mq_alu.size() > 0 && mq_ld.size() > 0) begin
        gnt = 1'b1; side = m_prio; m_prio = !m_prio;
      end else if (mq_alu.size() > 0) begin
        gnt = 1'b1; side = 1'b0;
      end else if (mq_ld.size() > 0) begin
        gnt = 1'b1; side = 1'b1;
      end
      if (gnt) begin
        e = side ? mq_ld.pop_front() : mq_alu.pop_front();
        exp_q.push_back({side, e.src, e.val});
      end
      if (a_acc && alu_src != '0) mq_alu.push_back({alu_src, alu_val});
      if (l_acc && ld_src != '0) mq_ld.push_back({ld_src, ld_val});
    end
    @(posedge clk);
    exp_valid = gnt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0; ld_valid = 1'b0; rdy = 1'b1; rb = 1'b0; rst = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_alu(input logic v, input int s, input logic [31:0] d);
    alu_valid = v; alu_src = ROB_BIT'(s); alu_val = d;
  endtask

  task automatic set_ld(input logic v, input int s, input logic [31:0] d);
    ld_valid = v; ld_src = ROB_BIT'(s); ld_val = d;
  endtask

  // monitor: every negedge compare the bus against the model
  always @(negedge clk) begin
    logic [W-1:0] want;
    if (started) begin
      check("cdb_valid", W'(cdb_valid), W'(exp_valid));
      if (cdb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_broadcast", {cdb_from_ld, cdb_src, cdb_val}, '0);
        end else begin
          want = exp_q.pop_front();
          check("broadcast", {cdb_from_ld, cdb_src, cdb_val}, want);
        end
      end
    end
  end

  initial begin
    logic a_pend, l_pend;
    rst = 1'b0; rdy = 1'b1; rb = 1'b0;
    set_alu(1'b0, 0, 32'h0);
    set_ld(1'b0, 0, 32'h0);
    // reset while offering results: nothing may be taken
    set_alu(1'b1, 9, 32'h11111111);
    step();
    step();
    started = 1'b1;
    check("reset_outputs", {cdb_valid, cdb_from_ld, cdb_src, cdb_val}, '0);

    // single ALU push
    rst = 1'b1;
    set_alu(1'b1, 3, 32'h12345678);
    step();
    idle(3);

    // simultaneous pushes, ALU first then alternating
    set_alu(1'b1, 1, 32'ha0000001); set_ld(1'b1, 2, 32'hb0000002); step();
    set_alu(1'b1, 4, 32'ha0000004); set_ld(1'b1, 5, 32'hb0000005); step();
    idle(6);

    // ALU every cycle with a busy load queue; producers hold until acked
    set_ld(1'b1, 7, 32'hc0000007); step();
    set_ld(1'b1, 8, 32'hc0000008); step();
    a_pend = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!a_pend) set_alu(1'b1, 1 + (i % 15), $urandom);
      set_ld(1'b1, 1 + ((i + 5) % 15), ld_val + 1);
      step();
      a_pend = !a_acc;
    end
    idle(8);

    // stall with two queued entries
    set_alu(1'b1, 6, 32'h06060606); set_ld(1'b1, 7, 32'h07070707); step();
    set_alu(1'b0, 0, 32'h0); set_ld(1'b0, 0, 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    idle(4);

    // fill both queues, then rollback with simultaneous pushes
    set_alu(1'b1, 10, 32'haaaa0000); set_ld(1'b1, 11, 32'hbbbb0000); rdy = 1'b0;
    step();
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_alu(1'b1, 10 + (i % 5), 32'haaaa0000 + i);
      set_ld(1'b1, 11 + (i % 4), 32'hbbbb0000 + i);
      step();
    end
    rb = 1'b1;
    step();
    rb = 1'b0;
    set_alu(1'b0, 0, 32'h0); set_ld(1'b0, 0, 32'h0);
    idle(4);

    // tag 0 is acked and dropped
    set_alu(1'b1, 0, 32'hdeadbeef); set_ld(1'b1, 0, 32'hdeadbeef); step();
    idle(4);

    // randomised traffic with held producers
    a_pend = 1'b0; l_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!a_pend && $urandom_range(0, 2) != 0)
        set_alu(1'b1, $urandom_range(0, 15), $urandom);
      else if (!a_pend)
        alu_valid = 1'b0;
      if (!l_pend && $urandom_range(0, 2) != 0)
        set_ld(1'b1, $urandom_range(0, 15), $urandom);
      else if (!l_pend)
        ld_valid = 1'b0;
      rdy = ($urandom_range(0, 5) != 0);
      rb  = ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 150) != 0);
      step();
      a_pend = alu_valid && !a_acc;
      l_pend = ld_valid && !l_acc;
    end

    idle(10);
    check("exp_q_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
